// File: rtl/adder4_accum_if.sv
// Handshake bundle between an upstream 4-bit adder, the accumulator and its consumer.
// The master modport is the environment side and the slave modport is the accumulator side.
interface adder4_accum_if;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] sum;
    logic       cout;
    logic [7:0] acc_out;
    logic       acc_valid;
    logic       out_ready;
    logic       ovf;
    logic       busy;

    modport master (
        output start, in_valid, sum, cout, out_ready,
        input  in_ready, acc_out, acc_valid, ovf, busy
    );

    modport slave (
        input  start, in_valid, sum, cout, out_ready,
        output in_ready, acc_out, acc_valid, ovf, busy
    );
endinterface

// File: rtl/adder4_accum.sv
// Accumulates N_SAMPLES 5-bit adder results ({cout,sum}) into a saturating 8-bit total.
// A three-state FSM (IDLE/ACC/DONE) drives registered handshake outputs.
module adder4_accum #(
    parameter int N_SAMPLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder4_accum_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [3:0] N_CNT = 4'(N_SAMPLES);

    state_t     state_reg;
    logic [3:0] count_reg;
    logic [7:0] acc_reg;
    logic       ovf_reg;
    logic       in_ready_reg;
    logic       acc_valid_reg;
    logic       busy_reg;

    logic [8:0] acc_next;
    logic [3:0] count_next;
    logic       xfer;

    // Nine-bit sum so that any carry past 255 is visible for saturation.
    assign acc_next   = {1'b0, acc_reg} + {4'b0000, bus.cout, bus.sum};
    assign count_next = count_reg + 4'd1;
    assign xfer       = bus.in_valid && in_ready_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= 4'd0;
            acc_reg       <= 8'd0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            acc_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg    <= ACC;
                        acc_reg      <= 8'd0;
                        ovf_reg      <= 1'b0;
                        count_reg    <= 4'd0;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                ACC: begin
                    if (xfer) begin
                        count_reg <= count_next;
                        if (acc_next[8]) begin
                            acc_reg <= 8'hFF;
                            ovf_reg <= 1'b1;
                        end else begin
                            acc_reg <= acc_next[7:0];
                        end
                        if (count_next == N_CNT) begin
                            state_reg     <= DONE;
                            in_ready_reg  <= 1'b0;
                            acc_valid_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Start seen on the exit cycle is dropped: it is only sampled in IDLE.
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        acc_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b0;
                    acc_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.acc_out   = acc_reg;
    assign bus.acc_valid = acc_valid_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_adder4_accum.sv
// Directed bench for adder4_accum: a default-size instance and a 12-sample instance
// for the saturation run, both sharing clock and reset.
module tb_adder4_accum;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [4:0] vec [8];

    adder4_accum_if bus_a ();
    adder4_accum_if bus_b ();

    adder4_accum #(.N_SAMPLES(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    adder4_accum #(.N_SAMPLES(12)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic xfer_a(input logic [4:0] v);
        bus_a.in_valid = 1'b1;
        {bus_a.cout, bus_a.sum} = v;
        tick();
        bus_a.in_valid = 1'b0;
        $display("xfer A value=%0d acc_out=%0d acc_valid=%0d", v, bus_a.acc_out, bus_a.acc_valid);
    endtask

    task automatic xfer_b(input logic [4:0] v);
        bus_b.in_valid = 1'b1;
        {bus_b.cout, bus_b.sum} = v;
        tick();
        bus_b.in_valid = 1'b0;
        $display("xfer B value=%0d acc_out=%0d ovf=%0d", v, bus_b.acc_out, bus_b.ovf);
    endtask

    initial begin
        int exp_acc;
        checks   = 0;
        failures = 0;
        vec = '{5'd11, 5'd13, 5'd16, 5'd16, 5'd16, 5'd14, 5'd15, 5'd23};

        rst_n = 1'b1;
        bus_a.start = 1'b0; bus_a.in_valid = 1'b0; bus_a.sum = 4'd0; bus_a.cout = 1'b0; bus_a.out_ready = 1'b0;
        bus_b.start = 1'b0; bus_b.in_valid = 1'b0; bus_b.sum = 4'd0; bus_b.cout = 1'b0; bus_b.out_ready = 1'b0;

        // Reset applied between clock edges must clear outputs immediately.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_acc_out", bus_a.acc_out, 0);
        chk("rst_acc_valid", bus_a.acc_valid, 0);
        chk("rst_in_ready", bus_a.in_ready, 0);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_ovf", bus_a.ovf, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle_busy", bus_a.busy, 0);

        // Nominal run, out_ready held high.
        bus_a.out_ready = 1'b1;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        chk("nom_busy", bus_a.busy, 1);
        chk("nom_in_ready", bus_a.in_ready, 1);
        chk("nom_acc_clr", bus_a.acc_out, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("nom_no_early_valid", bus_a.acc_valid, 0);
            xfer_a(vec[i]);
        end
        chk("nom_acc_valid", bus_a.acc_valid, 1);
        chk("nom_acc_out", bus_a.acc_out, 124);
        chk("nom_ovf", bus_a.ovf, 0);
        chk("nom_done_in_ready", bus_a.in_ready, 0);
        tick();
        chk("nom_idle_busy", bus_a.busy, 0);
        chk("nom_idle_valid", bus_a.acc_valid, 0);
        chk("nom_idle_hold", bus_a.acc_out, 124);

        // Stall after transfer 4, then backpressure on completion.
        bus_a.out_ready = 1'b0;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int i = 0; i < 4; i++) xfer_a(vec[i]);
        chk("stall_acc4", bus_a.acc_out, 56);
        for (int i = 0; i < 3; i++) begin
            {bus_a.cout, bus_a.sum} = 5'd31;
            tick();
            $display("stall cycle=%0d acc_out=%0d", i, bus_a.acc_out);
            chk("stall_acc_hold", bus_a.acc_out, 56);
            chk("stall_in_ready", bus_a.in_ready, 1);
        end
        for (int i = 4; i < 7; i++) xfer_a(vec[i]);
        chk("stall_acc7_not_done", bus_a.acc_valid, 0);
        xfer_a(vec[7]);
        chk("stall_acc_out", bus_a.acc_out, 124);
        chk("stall_acc_valid", bus_a.acc_valid, 1);
        for (int i = 0; i < 5; i++) begin
            bus_a.in_valid = i[0];
            {bus_a.cout, bus_a.sum} = 5'd31;
            tick();
            $display("backpressure cycle=%0d acc_out=%0d acc_valid=%0d", i, bus_a.acc_out, bus_a.acc_valid);
            chk("bp_acc_valid", bus_a.acc_valid, 1);
            chk("bp_acc_out", bus_a.acc_out, 124);
            chk("bp_in_ready", bus_a.in_ready, 0);
        end
        bus_a.in_valid = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        chk("bp_exit_busy", bus_a.busy, 0);
        tick();
        chk("bp_start_on_exit_ignored", bus_a.busy, 0);
        chk("bp_idle_hold", bus_a.acc_out, 124);

        // Ignored inputs: in_valid in IDLE, start held during ACC.
        bus_a.in_valid = 1'b1;
        {bus_a.cout, bus_a.sum} = 5'd31;
        tick();
        tick();
        bus_a.in_valid = 1'b0;
        chk("idle_in_valid_acc", bus_a.acc_out, 124);
        chk("idle_in_valid_busy", bus_a.busy, 0);
        bus_a.start = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) xfer_a(5'd2);
        chk("start_held_acc3", bus_a.acc_out, 6);
        for (int i = 0; i < 5; i++) xfer_a(5'd2);
        chk("start_held_acc8", bus_a.acc_out, 16);
        chk("start_held_valid", bus_a.acc_valid, 1);
        bus_a.start = 1'b0;
        tick();
        chk("start_held_idle", bus_a.busy, 0);

        // Saturation on the 12-sample instance.
        bus_b.out_ready = 1'b1;
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            xfer_b(5'd31);
            exp_acc = (31 * k > 255) ? 255 : 31 * k;
            chk("sat_acc", bus_b.acc_out, exp_acc);
            chk("sat_ovf", bus_b.ovf, (k >= 9) ? 1 : 0);
        end
        chk("sat_valid", bus_b.acc_valid, 1);
        tick();
        chk("sat_idle_ovf_hold", bus_b.ovf, 1);
        chk("sat_idle_acc_hold", bus_b.acc_out, 255);
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        chk("sat_restart_ovf_clr", bus_b.ovf, 0);
        chk("sat_restart_acc_clr", bus_b.acc_out, 0);

        // Asynchronous reset mid-run.
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int i = 0; i < 3; i++) xfer_a(5'd5);
        chk("mid_acc3", bus_a.acc_out, 15);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset asserted acc_out=%0d busy=%0d", bus_a.acc_out, bus_a.busy);
        chk("mid_rst_acc_out", bus_a.acc_out, 0);
        chk("mid_rst_busy", bus_a.busy, 0);
        chk("mid_rst_in_ready", bus_a.in_ready, 0);
        chk("mid_rst_acc_valid", bus_a.acc_valid, 0);
        chk("mid_rst_b_busy", bus_b.busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rst_wait_idle", bus_a.busy, 0);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int i = 0; i < 8; i++) xfer_a(5'd1);
        chk("mid_rst_rerun_acc", bus_a.acc_out, 8);
        chk("mid_rst_rerun_valid", bus_a.acc_valid, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
